// File: rtl/pattern_detect_pkg.sv
// Shared types and constants for the programmable pattern detector.
package pattern_detect_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConfigured,
        StArmed,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_MAX_LEN = 8;
    localparam int unsigned LEN_W           = $clog2(DEFAULT_MAX_LEN + 1);

endpackage

// File: rtl/pattern_match_core.sv
// History shift register, saturating fill counter and masked compare against the pattern.
module pattern_match_core
    import pattern_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
    localparam int unsigned LenW   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LenW-1:0]    len_i,
    output logic               hit_o
);

    localparam logic [LenW-1:0] FillMax = LenW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LenW-1:0]    fill_q, fill_d;
    logic [MAX_LEN-1:0] mask;

    // Candidate history/fill including the incoming bit; hit is judged on these.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], bit_i};
        fill_d = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
        mask   = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len_i));
        end
        hit_o = shift_i && (fill_d >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
    end

    // History is kept across matches so overlapping occurrences are seen.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Configurable overlap-aware serial pattern detector with config/arm/abort sequencing.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TO_W    = 16,
    localparam int unsigned LenW   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LenW-1:0]    cfg_len_i,
    input  logic [CNT_W-1:0]   cfg_count_i,
    input  logic [TO_W-1:0]    cfg_timeout_i,
    output logic               cfg_err_o,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               data_valid_i,
    input  logic               data_in_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timed_out_o
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LenW-1:0]    len_q, len_d;
    logic [CNT_W-1:0]   budget_q, budget_d;
    logic [TO_W-1:0]    to_lim_q, to_lim_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               match_q, match_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               err_q, err_d;

    logic               cfg_fire, len_ok;
    logic               core_clear, core_shift, hit;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_ready_o = (state_q != StArmed);
    assign busy_o      = (state_q == StArmed);
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign len_ok      = (cfg_len_i != '0) && (cfg_len_i <= LenW'(MAX_LEN));
    assign cnt_inc     = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (core_clear),
        .shift_i   (core_shift),
        .bit_i     (data_in_i),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    // Next-state, counter and output-register updates.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        budget_d    = budget_q;
        to_lim_d    = to_lim_q;
        to_cnt_d    = to_cnt_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        done_d      = done_q;
        tmo_d       = tmo_q;
        err_d       = 1'b0;
        core_clear  = 1'b0;
        core_shift  = 1'b0;

        case (state_q)
            StIdle, StConfigured, StDone: begin
                if (cfg_fire) begin
                    if (len_ok) begin
                        pat_d    = cfg_pattern_i;
                        len_d    = cfg_len_i;
                        budget_d = cfg_count_i;
                        to_lim_d = cfg_timeout_i;
                        done_d   = 1'b0;
                        tmo_d    = 1'b0;
                        state_d  = StConfigured;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (start_i && (state_q != StIdle)) begin
                    match_cnt_d = '0;
                    to_cnt_d    = '0;
                    done_d      = 1'b0;
                    tmo_d       = 1'b0;
                    core_clear  = 1'b1;
                    state_d     = StArmed;
                end
            end
            StArmed: begin
                core_shift = data_valid_i;
                if (abort_i) begin
                    // Any match in this cycle is discarded.
                    state_d = StConfigured;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (hit) begin
                        match_d     = 1'b1;
                        match_cnt_d = cnt_inc;
                    end
                    // A budget-completing match takes precedence over a coincident timeout.
                    if (hit && (budget_q != '0) && (cnt_inc == budget_q)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if ((to_lim_q != '0) && (to_cnt_d == to_lim_q)) begin
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pat_q       <= '0;
            len_q       <= '0;
            budget_q    <= '0;
            to_lim_q    <= '0;
            to_cnt_q    <= '0;
            match_cnt_q <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            budget_q    <= budget_d;
            to_lim_q    <= to_lim_d;
            to_cnt_q    <= to_cnt_d;
            match_cnt_q <= match_cnt_d;
            match_q     <= match_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = match_cnt_q;
    assign done_o      = done_q;
    assign timed_out_o = tmo_q;
    assign cfg_err_o   = err_q;

endmodule
